// File: rtl/fpga_led_status_ctrl.sv
// fpga_led_status_ctrl: per-channel LED driver (off / heartbeat / PWM / event
// pulse-stretch) with a sticky end-of-program override. All LEDs are solid on
// after a passing program exit and blink fast after a failing one.
module fpga_led_status_ctrl #(
  parameter int NUM_LED = 4,
  parameter int CNT_W   = 27,
  parameter int PWM_W   = 8,
  parameter int PULSE_W = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [2*NUM_LED-1:0]     mode_i,
  input  logic [PWM_W*NUM_LED-1:0] duty_i,
  input  logic [NUM_LED-1:0]       event_i,
  input  logic                     exit_valid_i,
  input  logic [31:0]              exit_value_i,
  output logic [NUM_LED-1:0]       led_o,
  output logic                     exit_fail_o
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_HEART   = 2'b01;
  localparam logic [1:0] MODE_PWM     = 2'b10;
  localparam logic [1:0] MODE_STRETCH = 2'b11;

  logic [CNT_W-1:0]   cnt_q;
  logic [PULSE_W-1:0] stretch_q [NUM_LED];
  logic [PULSE_W-1:0] stretch_d [NUM_LED];
  logic               exit_seen_q;
  logic               exit_fail_q;
  logic [NUM_LED-1:0] led_q;
  logic [NUM_LED-1:0] led_d;

  // Free-running counter shared by heartbeat, PWM and fail-blink; never stops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Per-channel next LED value and next stretch count, then the exit override.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      stretch_d[i] = '0;
      case (mode_i[2*i +: 2])
        MODE_OFF: begin
          led_d[i] = 1'b0;
        end
        MODE_HEART: begin
          led_d[i] = cnt_q[CNT_W-1];
        end
        MODE_PWM: begin
          led_d[i] = (cnt_q[PWM_W-1:0] < duty_i[PWM_W*i +: PWM_W]);
        end
        MODE_STRETCH: begin
          if (event_i[i]) begin
            stretch_d[i] = '1;
          end else if (stretch_q[i] != '0) begin
            stretch_d[i] = stretch_q[i] - 1'b1;
          end else begin
            stretch_d[i] = '0;
          end
          led_d[i] = event_i[i] | (stretch_q[i] != '0);
        end
        default: begin
          led_d[i] = 1'b0;
        end
      endcase
    end
    if (exit_seen_q) begin
      if (exit_fail_q) begin
        led_d = {NUM_LED{cnt_q[CNT_W-3]}};
      end else begin
        led_d = '1;
      end
    end
  end

  // Stretch counters; they keep running under the override but are hidden by it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LED; i++) begin
        stretch_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        stretch_q[i] <= stretch_d[i];
      end
    end
  end

  // Capture only the first program exit; later exits are ignored until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exit_seen_q <= 1'b0;
      exit_fail_q <= 1'b0;
    end else if (exit_valid_i && !exit_seen_q) begin
      exit_seen_q <= 1'b1;
      exit_fail_q <= (exit_value_i != 32'd0);
    end
  end

  // Registered LED drive, one cycle behind the mode/override decision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led_o       = led_q;
  assign exit_fail_o = exit_fail_q;

endmodule

// File: tb/tb_fpga_led_status_ctrl.sv
// tb_fpga_led_status_ctrl: randomized and directed stimulus for the LED status
// controller, checked against a cycle-indexed behavioural model.
module tb_fpga_led_status_ctrl;

  localparam int NUM_LED = 4;
  localparam int CNT_W   = 4;
  localparam int PWM_W   = 2;
  localparam int PULSE_W = 3;
  localparam longint STRETCH_LEN = longint'(1) << PULSE_W;

  logic                     clk_i;
  logic                     rst_ni;
  logic [2*NUM_LED-1:0]     mode_i;
  logic [PWM_W*NUM_LED-1:0] duty_i;
  logic [NUM_LED-1:0]       event_i;
  logic                     exit_valid_i;
  logic [31:0]              exit_value_i;
  logic [NUM_LED-1:0]       led_o;
  logic                     exit_fail_o;

  int checks = 0;
  int errors = 0;

  // Model state: cycle index since reset release, last in-mode event per channel,
  // and the captured exit outcome.
  longint t;
  longint last_ev [NUM_LED];
  bit     last_valid [NUM_LED];
  bit     m_seen;
  bit     m_fail;

  fpga_led_status_ctrl #(
    .NUM_LED(NUM_LED),
    .CNT_W  (CNT_W),
    .PWM_W  (PWM_W),
    .PULSE_W(PULSE_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mode_i      (mode_i),
    .duty_i      (duty_i),
    .event_i     (event_i),
    .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i),
    .led_o       (led_o),
    .exit_fail_o (exit_fail_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic modelReset();
    t = 0;
    m_seen = 1'b0;
    m_fail = 1'b0;
    for (int i = 0; i < NUM_LED; i++) begin
      last_ev[i] = 0;
      last_valid[i] = 1'b0;
    end
  endtask

  task automatic checkOutput(input logic [NUM_LED-1:0] exp_led, input logic exp_fail,
                             input string tag);
    checks++;
    assert (led_o === exp_led) else begin
      errors++;
      $error("[TB] FAIL %s led_o t=%0d got %b expected %b", tag, t, led_o, exp_led);
    end
    checks++;
    assert (exit_fail_o === exp_fail) else begin
      errors++;
      $error("[TB] FAIL %s exit_fail_o t=%0d got %b expected %b", tag, t, exit_fail_o, exp_fail);
    end
  endtask

  // Drive one cycle of inputs, predict the next edge, advance the model, then check.
  task automatic applyStimulus(input logic [2*NUM_LED-1:0] mode,
                               input logic [PWM_W*NUM_LED-1:0] duty,
                               input logic [NUM_LED-1:0] ev,
                               input logic exv, input logic [31:0] exval,
                               input string tag);
    logic [NUM_LED-1:0] exp_led;
    longint cnt;
    int m;
    int d;
    mode_i = mode;
    duty_i = duty;
    event_i = ev;
    exit_valid_i = exv;
    exit_value_i = exval;
    cnt = t % (longint'(1) << CNT_W);
    for (int i = 0; i < NUM_LED; i++) begin
      m = int'((mode >> (2*i)) & 3);
      d = int'((duty >> (PWM_W*i)) & ((1 << PWM_W) - 1));
      if (m_seen) begin
        exp_led[i] = m_fail ? (((cnt >> (CNT_W-3)) & 1) == 1) : 1'b1;
      end else if (m == 0) begin
        exp_led[i] = 1'b0;
      end else if (m == 1) begin
        exp_led[i] = (cnt >= (longint'(1) << (CNT_W-1)));
      end else if (m == 2) begin
        exp_led[i] = ((cnt % (longint'(1) << PWM_W)) < d);
      end else begin
        exp_led[i] = ev[i] || (last_valid[i] && (t - last_ev[i] <= STRETCH_LEN - 1));
      end
      if (m == 3) begin
        if (ev[i]) begin
          last_ev[i] = t;
          last_valid[i] = 1'b1;
        end
      end else begin
        last_valid[i] = 1'b0;
      end
    end
    if (exv && !m_seen) begin
      m_seen = 1'b1;
      m_fail = (exval != 0);
    end
    @(posedge clk_i);
    #1;
    t++;
    checkOutput(exp_led, m_fail, tag);
  endtask

  task automatic releaseReset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    modelReset();
  endtask

  initial begin
    logic [2*NUM_LED-1:0]     rmode;
    logic [PWM_W*NUM_LED-1:0] rduty;
    int high_cnt;

    rst_ni = 1'b0;
    mode_i = '0;
    duty_i = '0;
    event_i = '0;
    exit_valid_i = 1'b0;
    exit_value_i = '0;
    modelReset();
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput('0, 1'b0, "reset");
    releaseReset();

    $display("[TB] heartbeat on all channels");
    repeat (20) applyStimulus(8'b01_01_01_01, '0, '0, 1'b0, 32'd0, "heartbeat");

    $display("[TB] PWM duties 0,2,3,1");
    repeat (12) applyStimulus(8'b10_10_10_10, 8'b01_11_10_00, '0, 1'b0, 32'd0, "pwm");

    $display("[TB] single pulse stretch length");
    applyStimulus(8'b00_00_00_11, '0, 4'b0001, 1'b0, 32'd0, "stretch_ev");
    high_cnt = (led_o[0] === 1'b1) ? 1 : 0;
    repeat (12) begin
      applyStimulus(8'b00_00_00_11, '0, '0, 1'b0, 32'd0, "stretch");
      if (led_o[0] === 1'b1) high_cnt++;
    end
    checks++;
    assert (high_cnt == int'(STRETCH_LEN)) else begin
      errors++;
      $error("[TB] FAIL stretch_len got %0d expected %0d", high_cnt, STRETCH_LEN);
    end

    $display("[TB] retrigger and mode-change abort");
    applyStimulus(8'b00_00_11_11, '0, 4'b0011, 1'b0, 32'd0, "retrig");
    repeat (4) applyStimulus(8'b00_00_11_11, '0, '0, 1'b0, 32'd0, "retrig");
    applyStimulus(8'b00_00_11_11, '0, 4'b0001, 1'b0, 32'd0, "retrig");
    applyStimulus(8'b00_00_00_11, '0, '0, 1'b0, 32'd0, "abort");
    repeat (3) applyStimulus(8'b00_00_11_11, '0, '0, 1'b0, 32'd0, "abort");
    repeat (12) applyStimulus(8'b00_00_11_11, '0, '0, 1'b0, 32'd0, "drain");

    $display("[TB] randomized modes, duties and events");
    for (int k = 0; k < 40; k++) begin
      rmode = 8'($urandom);
      rduty = 8'($urandom);
      repeat ($urandom_range(3, 20)) begin
        applyStimulus(rmode, rduty, 4'($urandom & $urandom & $urandom), 1'b0,
                      32'd0, "random");
      end
    end

    $display("[TB] pass exit override, later fail exit ignored");
    repeat (5) applyStimulus(8'b11_10_01_00, 8'b10_10_10_10, '0, 1'b0, 32'd0, "pre_pass");
    applyStimulus(8'b11_10_01_00, 8'b10_10_10_10, '0, 1'b1, 32'd0, "pass_cap");
    repeat (10) applyStimulus(8'($urandom), 8'($urandom), 4'($urandom), 1'b0, 32'd0, "pass");
    applyStimulus(8'($urandom), 8'($urandom), 4'($urandom), 1'b1, 32'd5, "pass_ignore");
    repeat (10) applyStimulus(8'($urandom), 8'($urandom), 4'($urandom),
                              1'($urandom), $urandom, "pass_ovr");

    $display("[TB] reset and fail exit override");
    rst_ni = 1'b0;
    #1;
    checkOutput('0, 1'b0, "reset_pass");
    releaseReset();
    repeat (7) applyStimulus(8'b01_01_10_11, 8'b11_11_11_11, 4'b0001, 1'b0, 32'd0, "pre_fail");
    applyStimulus(8'b01_01_10_11, 8'b11_11_11_11, '0, 1'b1, 32'h1, "fail_cap");
    repeat (20) applyStimulus(8'($urandom), 8'($urandom), 4'($urandom),
                              1'($urandom), $urandom, "fail_ovr");

    $display("[TB] async reset mid-cycle during fail override");
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput('0, 1'b0, "async_reset");
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput('0, 1'b0, "held_reset");
    releaseReset();
    repeat (20) applyStimulus(8'b01_01_01_01, '0, '0, 1'b0, 32'd0, "post_reset");
    for (int k = 0; k < 10; k++) begin
      rmode = 8'($urandom);
      rduty = 8'($urandom);
      repeat ($urandom_range(3, 15)) begin
        applyStimulus(rmode, rduty, 4'($urandom & $urandom), 1'b0, 32'd0, "random2");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
